axi_rd_arbiter: RTL and testbench

- Arbitrates the shared AXI read channel between the instruction-cache refill master (port 0) and the data-cache miss master (port 1).
- Issues exactly one outstanding read burst at a time.
- Routes R beats back to the granting master and checks burst length against RLAST.
- Sits between Icache_wrapper / Dcache_wrapper miss ports and the top-level M_AXI read channel.
- Replaces the read half of the generic crossbar.

---
 rtl/axi_rd_pkg.sv | 14 +
 rtl/rd_arb_grant.sv | 29 ++
 rtl/axi_rd_arbiter.sv | 137 +++++++++++++
 tb/tb_axi_rd_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_pkg.sv
// Shared types and constants for the AXI read-channel arbiter.
package axi_rd_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAr   = 2'd1,
    StR    = 2'd2
  } rd_state_e;

  localparam logic       ICACHE_PORT   = 1'b0;
  localparam logic       DCACHE_PORT   = 1'b1;
  localparam logic [2:0] AXI_SIZE_WORD = 3'd2;

endpackage

// File: rtl/rd_arb_grant.sv
// Combinational 2-way grant select; RR_ARB_EN selects round-robin, else D-cache fixed priority.
module rd_arb_grant
  import axi_rd_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       grant_o,
  output logic       valid_o
);

  assign valid_o = |req_i;

`ifdef RR_ARB_EN
  always_comb begin
    grant_o = ICACHE_PORT;
    if (req_i[DCACHE_PORT] && req_i[ICACHE_PORT]) begin
      // On contention the port that did not win last time goes first.
      grant_o = ~last_grant_i;
    end else if (req_i[DCACHE_PORT]) begin
      grant_o = DCACHE_PORT;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
  assign grant_o = req_i[DCACHE_PORT] ? DCACHE_PORT : ICACHE_PORT;
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-master AXI read arbiter, one outstanding burst, with RLAST/RID checking.
// Optional round-robin arbitration under RR_ARB_EN (default: port 1 fixed priority).
module axi_rd_arbiter
  import axi_rd_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2*ADDR_W-1:0] s_araddr,
  input  logic [2*LEN_W-1:0]  s_arlen,
  input  logic [1:0]          s_arvalid,
  output logic [1:0]          s_arready,
  output logic [2*DATA_W-1:0] s_rdata,
  output logic [1:0]          s_rvalid,
  output logic [1:0]          s_rlast,
  input  logic [1:0]          s_rready,
  output logic [3:0]          m_arid,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [LEN_W-1:0]    m_arlen,
  output logic [2:0]          m_arsize,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [3:0]          m_rid,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_rvalid,
  input  logic                m_rlast,
  output logic                m_rready,
  output logic                err
);

  rd_state_e         state_q, state_d;
  logic              grant_q, grant_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [LEN_W-1:0]  arlen_q, arlen_d;
  logic [LEN_W:0]    beat_cnt_q, beat_cnt_d;
  logic              err_q, err_d;
  logic              arb_grant, arb_valid, arb_last;
  logic [2:0]        unused_rid;

  assign unused_rid = m_rid[3:1];

  rd_arb_grant u_grant (
    .req_i        (s_arvalid),
    .last_grant_i (arb_last),
    .grant_o      (arb_grant),
    .valid_o      (arb_valid)
  );

`ifdef RR_ARB_EN
  logic last_grant_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b0;
    end else if (state_q == StIdle && arb_valid) begin
      last_grant_q <= arb_grant;
    end
  end
  assign arb_last = last_grant_q;
`else
  assign arb_last = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    araddr_d   = araddr_q;
    arlen_d    = arlen_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    s_arready  = '0;
    s_rvalid   = '0;
    s_rlast    = '0;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          grant_d    = arb_grant;
          araddr_d   = arb_grant ? s_araddr[2*ADDR_W-1:ADDR_W] : s_araddr[ADDR_W-1:0];
          arlen_d    = arb_grant ? s_arlen[2*LEN_W-1:LEN_W] : s_arlen[LEN_W-1:0];
          beat_cnt_d = '0;
          state_d    = StAr;
          // Ack is combinational; suppress it while reset holds the FSM.
          s_arready[arb_grant] = ~reset;
        end
      end
      StAr: begin
        m_arvalid = 1'b1;
        if (m_arready) state_d = StR;
      end
      StR: begin
        m_rready          = s_rready[grant_q];
        s_rvalid[grant_q] = m_rvalid;
        s_rlast[grant_q]  = m_rlast;
        if (m_rvalid && m_rready) begin
          if (beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + 1'b1;
          if (m_rid[0] != grant_q) err_d = 1'b1;
          if (m_rlast) begin
            // beat_cnt counts beats before this one, so a correct burst ends at arlen.
            if (beat_cnt_q != {1'b0, arlen_q}) err_d = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      grant_q    <= 1'b0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

  assign m_arid   = {3'b000, grant_q};
  assign m_araddr = araddr_q;
  assign m_arlen  = arlen_q;
  assign m_arsize = AXI_SIZE_WORD;
  assign s_rdata  = {2{m_rdata}};
  assign err      = err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter with an autonomous slave model.
module tb_axi_rd_arbiter;
  import axi_rd_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] s_araddr;
  logic [7:0]  s_arlen;
  logic [1:0]  s_arvalid, s_arready, s_rvalid, s_rlast, s_rready;
  logic [63:0] s_rdata;
  logic [3:0]  m_arid, m_arlen, m_rid;
  logic [31:0] m_araddr, m_rdata;
  logic [2:0]  m_arsize;
  logic        m_arvalid, m_arready, m_rvalid, m_rlast, m_rready, err;

  axi_rd_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .s_araddr  (s_araddr),
    .s_arlen   (s_arlen),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_rdata   (s_rdata),
    .s_rvalid  (s_rvalid),
    .s_rlast   (s_rlast),
    .s_rready  (s_rready),
    .m_arid    (m_arid),
    .m_araddr  (m_araddr),
    .m_arlen   (m_arlen),
    .m_arsize  (m_arsize),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_rid     (m_rid),
    .m_rdata   (m_rdata),
    .m_rvalid  (m_rvalid),
    .m_rlast   (m_rlast),
    .m_rready  (m_rready),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  len;
    logic        id;
  } ar_exp_t;

  typedef struct {
    logic        port;
    logic [31:0] data;
    logic        last;
  } r_exp_t;

  ar_exp_t ar_q[$];
  r_exp_t  r_q[$];
  ar_exp_t mon_ar;
  r_exp_t  mon_r;
  int      n_checks = 0;
  int      n_pass   = 0;

  // Slave model controls and state
  int          ar_delay = 0;
  bit          early_en = 1'b0;
  bit          rid_flip = 1'b0;
  int          ph = 0;
  int          wt = 0;
  int          sl_beat = 0;
  logic [31:0] sl_addr;
  logic [3:0]  sl_len;
  logic        sl_id;
  bit          ar_hs = 1'b0;
  bit          r_hs = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int p, input logic [31:0] addr, input logic [3:0] len,
                           input int nbeats);
    ar_exp_t ea;
    r_exp_t  er;
    ea.addr = addr;
    ea.len  = len;
    ea.id   = p[0];
    ar_q.push_back(ea);
    for (int i = 0; i < nbeats; i++) begin
      er.port = p[0];
      er.data = addr + 32'(4 * i);
      er.last = (i == nbeats - 1);
      r_q.push_back(er);
    end
    s_araddr[p*32 +: 32] = addr;
    s_arlen[p*4 +: 4]    = len;
    s_arvalid[p]         = 1'b1;
  endtask

  task automatic wait_ack(input int p);
    bit         got = 1'b0;
    logic [1:0] oh;
    oh = 2'b01 << p;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (s_arready[p]) begin
        got = 1'b1;
        break;
      end
      cyc();
    end
    check("arready_seen", got, 1);
    if (got) check("arready_onehot", s_arready, oh);
    cyc();
    s_arvalid[p] = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && (r_q.size() != 0 || ar_q.size() != 0); i++) cyc();
    check("drain_r", r_q.size(), 0);
    check("drain_ar", ar_q.size(), 0);
    cyc();
  endtask

  task automatic slave_drive();
    m_rvalid = 1'b1;
    m_rdata  = sl_addr + 32'(4 * sl_beat);
    m_rlast  = (sl_beat == (early_en ? 1 : int'(sl_len)));
    m_rid    = {3'b000, sl_id ^ rid_flip};
  endtask

  // Handshake sampling for the slave, away from the active edge
  always @(negedge clk) begin
    ar_hs = m_arvalid && m_arready;
    r_hs  = m_rvalid && m_rready;
    if (ar_hs) begin
      sl_addr = m_araddr;
      sl_len  = m_arlen;
      sl_id   = m_arid[0];
    end
  end

  initial begin
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rlast   = 1'b0;
    m_rdata   = '0;
    m_rid     = '0;
    forever begin
      cyc();
      if (reset) begin
        ph = 0;
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rlast   = 1'b0;
      end else if (ph == 2) begin
        if (r_hs) begin
          if (m_rlast) begin
            ph = 0;
            m_rvalid = 1'b0;
            m_rlast  = 1'b0;
          end else begin
            sl_beat++;
          end
        end
        if (ph == 2) slave_drive();
      end else if (ph == 1) begin
        if (ar_hs) begin
          m_arready = 1'b0;
          ph = 2;
          sl_beat = 0;
          slave_drive();
        end else if (wt == 0) begin
          m_arready = 1'b1;
        end else begin
          m_arready = 1'b0;
          wt--;
        end
      end else if (m_arvalid) begin
        wt = ar_delay;
        ph = 1;
        if (wt == 0) m_arready = 1'b1;
        else begin
          m_arready = 1'b0;
          wt--;
        end
      end
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (m_arvalid && m_arready) begin
        if (ar_q.size() == 0) check("ar_unexpected", ar_q.size(), 1);
        else begin
          mon_ar = ar_q.pop_front();
          check("m_araddr", m_araddr, mon_ar.addr);
          check("m_arlen", m_arlen, mon_ar.len);
          check("m_arid", m_arid, {3'b000, mon_ar.id});
          check("m_arsize", m_arsize, 3'd2);
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (s_rvalid[p] && s_rready[p]) begin
          check("rvalid_onehot", s_rvalid, 2'b01 << p);
          if (r_q.size() == 0) check("r_unexpected", r_q.size(), 1);
          else begin
            mon_r = r_q.pop_front();
            check("r_port", p, mon_r.port);
            check("r_data", s_rdata[p*32 +: 32], mon_r.data);
            check("r_last", s_rlast[p], mon_r.last);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int sz;
    bit hit;
    reset     = 1'b1;
    s_araddr  = '0;
    s_arlen   = '0;
    s_arvalid = '0;
    s_rready  = 2'b11;
    repeat (3) cyc();
    check("rst_state", dut.state_q, StIdle);
    check("rst_arvalid", m_arvalid, 0);
    check("rst_arready", s_arready, 0);
    check("rst_rvalid", s_rvalid, 0);
    check("rst_rready", m_rready, 0);
    check("rst_err", err, 0);
    check("rst_araddr", m_araddr, 0);
    check("rst_arid", m_arid, 0);
    reset = 1'b0;
    cyc();

    // Single I-cache burst
    drive_req(0, 32'h1FC0_0000, 4'd3, 4);
    wait_ack(0);
    wait_done();
    check("t1_err", err, 0);
    check("t1_idle", dut.state_q, StIdle);

    // Simultaneous pair: D-cache wins (last_grant still 0 in round-robin too)
    drive_req(1, 32'h0000_2000, 4'd0, 1);
    drive_req(0, 32'h0000_1000, 4'd3, 4);
    wait_ack(1);
    wait_ack(0);
    wait_done();

    // D-cache alone, then a pair: round-robin favours port 0, fixed favours port 1
    drive_req(1, 32'h0000_A000, 4'd1, 2);
    wait_ack(1);
    wait_done();
`ifdef RR_ARB_EN
    drive_req(0, 32'h0000_B000, 4'd0, 1);
    drive_req(1, 32'h0000_C000, 4'd0, 1);
    wait_ack(0);
    wait_ack(1);
`else
    drive_req(1, 32'h0000_C000, 4'd0, 1);
    drive_req(0, 32'h0000_B000, 4'd0, 1);
    wait_ack(1);
    wait_ack(0);
`endif
    wait_done();

    // Slave stalls the address phase; a competing request must not be acked
    ar_delay = 5;
    drive_req(1, 32'h0000_3000, 4'd1, 2);
    wait_ack(1);
    drive_req(0, 32'h0000_3100, 4'd2, 3);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("ars_arvalid", m_arvalid, 1);
      check("ars_araddr", m_araddr, 32'h0000_3000);
      check("ars_arlen", m_arlen, 4'd1);
      check("ars_noack", s_arready, 0);
      cyc();
    end
    wait_ack(0);
    wait_done();
    ar_delay = 0;

    // Master stalls mid-burst
    drive_req(0, 32'h0000_4000, 4'd3, 4);
    wait_ack(0);
    for (int i = 0; i < 100 && r_q.size() > 2; i++) cyc();
    check("stall_reach", r_q.size(), 2);
    sz = r_q.size();
    s_rready[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_mrready", m_rready, 0);
      cyc();
    end
    check("stall_nodrop", r_q.size(), sz);
    s_rready[0] = 1'b1;
    wait_done();
    check("stall_err", err, 0);

    // Early RLAST
    early_en = 1'b1;
    drive_req(0, 32'h0000_5000, 4'd3, 2);
    wait_ack(0);
    wait_done();
    early_en = 1'b0;
    check("early_err", err, 1);
    drive_req(1, 32'h0000_6000, 4'd0, 1);
    wait_ack(1);
    wait_done();
    check("early_sticky", err, 1);
    check("early_idle", dut.state_q, StIdle);

    // Reset while in R
    s_rready = 2'b10;
    drive_req(0, 32'h0000_7000, 4'd3, 4);
    wait_ack(0);
    hit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (dut.state_q == StR) begin
        hit = 1'b1;
        break;
      end
      cyc();
    end
    check("mid_reach_r", hit, 1);
    cyc();
    reset = 1'b1;
    cyc();
    check("mid_state", dut.state_q, StIdle);
    check("mid_arvalid", m_arvalid, 0);
    check("mid_err", err, 0);
    check("mid_rvalid", s_rvalid, 0);
    check("mid_rready", m_rready, 0);
    reset = 1'b0;
    s_rready = 2'b11;
    r_q.delete();
    ar_q.delete();
    cyc();
    drive_req(1, 32'h0000_8000, 4'd2, 3);
    wait_ack(1);
    wait_done();
    check("post_rst_err", err, 0);

    // Wrong RID on the returned beats
    rid_flip = 1'b1;
    drive_req(0, 32'h0000_9000, 4'd0, 1);
    wait_ack(0);
    wait_done();
    rid_flip = 1'b0;
    check("rid_err", err, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
